// File: rtl/pcap_pkg.sv
// rtl/pcap_pkg.sv - shared constants and state encoding for the position-capture packer
package pcap_pkg;

    localparam int POS_W = 32;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_TOO_FAST   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN    = 2'd2;
    localparam logic [1:0] ERR_EMPTY_MASK = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/pcap_sync_fifo.sv
// rtl/pcap_sync_fifo.sv - show-ahead synchronous FIFO with registered head word
// The head register adds one cycle of write-to-valid latency; count includes it.
module pcap_sync_fifo
    import pcap_pkg::*;
#(
    parameter int WIDTH = POS_W,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [AW:0]      o_count,
    output logic             o_full
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_mem_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic w_pop;
    logic w_load;

    assign w_pop  = r_out_valid & i_rd_en;
    assign w_load = (r_mem_cnt != '0) && (!r_out_valid || w_pop);

    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_out_data  <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_mem_cnt <= r_mem_cnt + (AW+1)'(i_wr_en) - (AW+1)'(w_load);
        end
    end

    assign o_rd_data  = r_out_data;
    assign o_rd_valid = r_out_valid;
    assign o_count    = r_mem_cnt + (AW+1)'(r_out_valid);
    assign o_full     = (o_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/pcap_pos_packer.sv
// rtl/pcap_pos_packer.sv - masked position snapshot packer with run control and word stream
// Each accepted capture serialises an optional count header plus the masked channels into the FIFO.
module pcap_pos_packer
    import pcap_pkg::*;
#(
    parameter int NUM_POS = 32,
    parameter bit HDR_EN  = 1'b1,
    parameter int FIFO_AW = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     arm_i,
    input  logic                     disarm_i,
    input  logic                     enable_i,
    input  logic                     capture_i,
    input  logic [NUM_POS-1:0]       mask_i,
    input  logic [NUM_POS*POS_W-1:0] posbus_i,
    output logic [POS_W-1:0]         dat_o,
    output logic                     dat_valid_o,
    input  logic                     dat_ready_i,
    output logic                     active_o,
    output logic                     done_o,
    output logic [1:0]               err_o,
    output logic [31:0]              sample_cnt_o
);

    localparam int DEPTH = 2 ** FIFO_AW;

    state_t                   r_state;
    logic [NUM_POS-1:0]       r_mask;
    logic [7:0]               r_w;
    logic                     r_en_d;
    logic                     r_active;
    logic                     r_done;
    logic [1:0]               r_err;
    logic [31:0]              r_cnt;

    logic [NUM_POS*POS_W-1:0] r_shadow;
    logic [NUM_POS-1:0]       r_pend;
    logic                     r_hdr_pend;
    logic [31:0]              r_hdr;
    logic [7:0]               r_rem;

    logic [7:0]               w_pop;
    logic [7:0]               w_words;
    logic [NUM_POS-1:0]       w_lsb;
    logic [POS_W-1:0]         w_ch_word;
    logic                     w_wr_en;
    logic [POS_W-1:0]         w_wr_data;
    logic [FIFO_AW:0]         w_fifo_cnt;
    logic                     w_fifo_full;
    logic                     w_ser_free;
    logic                     w_room;
    logic                     w_cap;
    logic                     w_fall;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_POS; k++) begin
            w_pop = w_pop + 8'(mask_i[k]);
        end
    end

    assign w_words = w_pop + 8'(HDR_EN);

    // Lowest pending channel is emitted next, giving ascending index order.
    always_comb begin
        w_lsb     = r_pend & (~r_pend + NUM_POS'(1));
        w_ch_word = '0;
        for (int k = 0; k < NUM_POS; k++) begin
            if (w_lsb[k]) begin
                w_ch_word = w_ch_word | r_shadow[k*POS_W +: POS_W];
            end
        end
    end

    assign w_wr_en   = (r_rem != 8'd0);
    assign w_wr_data = r_hdr_pend ? r_hdr : w_ch_word;

    // The serialiser is free on its last word, and that word is reserved in the space check.
    assign w_ser_free = (r_rem <= 8'd1);
    assign w_room     = (32'(w_fifo_cnt) + 32'(r_rem) + 32'(r_w)) <= 32'(DEPTH);
    assign w_cap      = capture_i & enable_i;
    assign w_fall     = r_en_d & ~enable_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_w        <= '0;
            r_en_d     <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= ERR_NONE;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_pend     <= '0;
            r_hdr_pend <= 1'b0;
            r_hdr      <= '0;
            r_rem      <= '0;
        end else begin
            r_en_d <= enable_i;
            r_done <= 1'b0;

            if (w_wr_en) begin
                r_rem <= r_rem - 8'd1;
                if (r_hdr_pend) begin
                    r_hdr_pend <= 1'b0;
                end else begin
                    r_pend <= r_pend & ~w_lsb;
                end
            end

            case (r_state)
                IDLE: begin
                    if (arm_i && !disarm_i) begin
                        r_mask   <= mask_i;
                        r_w      <= w_words;
                        r_cnt    <= '0;
                        r_active <= 1'b1;
                        if (w_words == 8'd0) begin
                            r_err   <= ERR_EMPTY_MASK;
                            r_state <= DRAIN;
                        end else begin
                            r_err   <= ERR_NONE;
                            r_state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (disarm_i || w_fall) begin
                        r_state <= DRAIN;
                    end else if (w_cap) begin
                        if (!w_ser_free) begin
                            r_err   <= ERR_TOO_FAST;
                            r_state <= DRAIN;
                        end else if (!w_room || w_fifo_full) begin
                            r_err   <= ERR_OVERRUN;
                            r_state <= DRAIN;
                        end else begin
                            r_cnt      <= r_cnt + 32'd1;
                            r_hdr      <= r_cnt + 32'd1;
                            r_shadow   <= posbus_i;
                            r_pend     <= r_mask;
                            r_hdr_pend <= HDR_EN;
                            r_rem      <= r_w;
                        end
                    end
                end
                DRAIN: begin
                    if (r_rem == 8'd0 && w_fifo_cnt == '0) begin
                        r_done   <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pcap_sync_fifo #(
        .WIDTH (POS_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (dat_ready_i),
        .o_rd_data  (dat_o),
        .o_rd_valid (dat_valid_o),
        .o_count    (w_fifo_cnt),
        .o_full     (w_fifo_full)
    );

    assign active_o     = r_active;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign sample_cnt_o = r_cnt;

endmodule

// File: tb/tb_pcap_pos_packer.sv
// tb/tb_pcap_pos_packer.sv - self-checking bench for pcap_pos_packer
module tb_pcap_pos_packer;

    logic          clk = 1'b0;
    logic          reset_n, arm, disarm, enable, capture, ready;
    logic [31:0]   mask;
    logic [1023:0] posbus;

    logic [31:0] dat_a, cnt_a, dat_b, cnt_b;
    logic        valid_a, active_a, done_a, valid_b, active_b, done_b;
    logic [1:0]  err_a, err_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pcap_pos_packer #(.NUM_POS(32), .HDR_EN(1'b1), .FIFO_AW(3)) u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .arm_i(arm), .disarm_i(disarm),
        .enable_i(enable), .capture_i(capture), .mask_i(mask), .posbus_i(posbus),
        .dat_o(dat_a), .dat_valid_o(valid_a), .dat_ready_i(ready),
        .active_o(active_a), .done_o(done_a), .err_o(err_a), .sample_cnt_o(cnt_a)
    );

    pcap_pos_packer #(.NUM_POS(8), .HDR_EN(1'b0), .FIFO_AW(4)) u_dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .arm_i(arm), .disarm_i(disarm),
        .enable_i(enable), .capture_i(capture), .mask_i(mask[7:0]), .posbus_i(posbus[255:0]),
        .dat_o(dat_b), .dat_valid_o(valid_b), .dat_ready_i(ready),
        .active_o(active_b), .done_o(done_b), .err_o(err_b), .sample_cnt_o(cnt_b)
    );

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid_a && ready) got_a.push_back(dat_a);
            if (valid_b && ready) got_b.push_back(dat_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arm = 0; disarm = 0; enable = 0; capture = 0; ready = 0; mask = 0;
        reset_n = 0;
        step();
        step();
        reset_n = 1;
        got_a.delete(); got_b.delete(); exp_q.delete();
    endtask

    task automatic randomize_bus();
        for (int k = 0; k < 32; k++) posbus[k*32 +: 32] = $urandom();
    endtask

    task automatic pulse_arm();
        arm = 1; step(); arm = 0;
    endtask

    task automatic pulse_disarm();
        disarm = 1; step(); disarm = 0;
    endtask

    task automatic wait_done(input bit sel, input int max, output bit seen);
        seen = 0;
        for (int i = 0; i < max; i++) begin
            step();
            if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
                seen = 1;
                break;
            end
        end
    endtask

    // Reference: a sample is its count header (if enabled) then every selected channel, lowest first.
    task automatic model_sample(input logic [31:0] m, input logic [1023:0] pb,
                                input bit hdr, input int count, input int nch);
        if (hdr) exp_q.push_back(32'(count));
        for (int k = 0; k < nch; k++)
            if (m[k]) exp_q.push_back(pb[k*32 +: 32]);
    endtask

    function automatic int first_diff(input bit sel);
        int n;
        n = sel ? got_b.size() : got_a.size();
        if (n != exp_q.size()) return -2;
        for (int i = 0; i < n; i++)
            if ((sel ? got_b[i] : got_a[i]) !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        int d;
        arm = 0; disarm = 0; enable = 1; capture = 1; ready = 1; mask = 32'hFFFF_FFFF;
        randomize_bus();
        reset_n = 0;
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        checks++; if (dat_a !== 32'd0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat_a); end
        checks++; if (active_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_ctl active=%b done=%b exp=0/0", active_a, done_a); end
        checks++; if (err_a !== 2'd0 || cnt_a !== 32'd0) begin errors++; $display("FAIL reset_status err=%0d cnt=%0d exp=0/0", err_a, cnt_a); end
        checks++; if (active_b !== 1'b0 || err_b !== 2'd0) begin errors++; $display("FAIL reset_b active=%b err=%0d exp=0/0", active_b, err_b); end
        do_reset();
    endtask

    task automatic test_single();
        bit seen;
        int d;
        logic [1023:0] snap;
        do_reset();
        mask = 32'h5; randomize_bus();
        posbus[31:0] = 32'h11; posbus[95:64] = 32'h33;
        ready = 1; enable = 1;
        step();
        pulse_arm();
        checks++; if (active_a !== 1'b1) begin errors++; $display("FAIL single_active got=%b exp=1", active_a); end
        capture = 1; snap = posbus; step(); capture = 0;
        model_sample(32'h5, snap, 1, 1, 32);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_valid_n got=%b exp=0", valid_a); end
        step();
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_valid_n1 got=%b exp=0", valid_a); end
        step();
        checks++; if (valid_a !== 1'b1 || dat_a !== 32'd1) begin errors++; $display("FAIL single_first_word valid=%b dat=%h exp=1/00000001", valid_a, dat_a); end
        repeat (6) step();
        pulse_disarm();
        wait_done(0, 20, seen);
        checks++; if (!seen || active_a !== 1'b0 || err_a !== 2'd0) begin errors++; $display("FAIL single_done seen=%b active=%b err=%0d exp=1/0/0", seen, active_a, err_a); end
        step();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done_a); end
        d = first_diff(0);
        checks++; if (d != -1) begin errors++; $display("FAIL single_words diff=%0d got_n=%0d exp_n=%0d", d, got_a.size(), exp_q.size()); end
    endtask

    task automatic test_too_fast();
        bit seen;
        int d;
        logic [1023:0] snap;
        do_reset();
        mask = 32'h5; randomize_bus(); ready = 1; enable = 1;
        step();
        pulse_arm();
        capture = 1; snap = posbus; step(); capture = 0;
        model_sample(32'h5, snap, 1, 1, 32);
        randomize_bus();
        step();
        capture = 1; step(); capture = 0;
        checks++; if (err_a !== 2'd1 || cnt_a !== 32'd1) begin errors++; $display("FAIL fast_err err=%0d cnt=%0d exp=1/1", err_a, cnt_a); end
        wait_done(0, 30, seen);
        checks++; if (!seen || err_a !== 2'd1) begin errors++; $display("FAIL fast_done seen=%b err=%0d exp=1/1", seen, err_a); end
        d = first_diff(0);
        checks++; if (d != -1) begin errors++; $display("FAIL fast_words diff=%0d got_n=%0d exp_n=%0d", d, got_a.size(), exp_q.size()); end
    endtask

    task automatic test_overrun();
        bit seen;
        int d;
        logic [1023:0] snap;
        do_reset();
        mask = 32'hF; randomize_bus(); ready = 0; enable = 1;
        step();
        pulse_arm();
        capture = 1; snap = posbus; step(); capture = 0;
        model_sample(32'hF, snap, 1, 1, 32);
        repeat (4) step();
        capture = 1; step(); capture = 0;
        checks++; if (err_a !== 2'd2 || cnt_a !== 32'd1) begin errors++; $display("FAIL overrun_err err=%0d cnt=%0d exp=2/1", err_a, cnt_a); end
        repeat (3) step();
        checks++; if (got_a.size() != 0 || active_a !== 1'b1) begin errors++; $display("FAIL overrun_held words=%0d active=%b exp=0/1", got_a.size(), active_a); end
        ready = 1;
        wait_done(0, 40, seen);
        checks++; if (!seen || err_a !== 2'd2) begin errors++; $display("FAIL overrun_done seen=%b err=%0d exp=1/2", seen, err_a); end
        d = first_diff(0);
        checks++; if (d != -1) begin errors++; $display("FAIL overrun_words diff=%0d got_n=%0d exp_n=%0d", d, got_a.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back_stall();
        bit seen, hold;
        int d, nb;
        logic [31:0] m, hv;
        do_reset();
        m = 0;
        while ($countones(m) < 3) m[$urandom_range(31, 0)] = 1'b1;
        mask = m; randomize_bus(); enable = 1;
        step();
        pulse_arm();
        nb = 0;
        for (int c = 0; c < 60; c++) begin
            ready = (c % 2 == 1);
            capture = (c == 2 || c == 6);
            if (c == 4) randomize_bus();
            if (capture) begin
                nb++;
                model_sample(m, posbus, 1, nb, 32);
            end
            hold = valid_a && !ready;
            hv = dat_a;
            step();
            if (hold) begin
                checks++;
                if (valid_a !== 1'b1 || dat_a !== hv) begin errors++; $display("FAIL stall_hold cyc=%0d valid=%b dat=%h exp=1/%h", c, valid_a, dat_a, hv); end
            end
        end
        capture = 0; ready = 1;
        checks++; if (err_a !== 2'd0 || cnt_a !== 32'd2) begin errors++; $display("FAIL b2b_status err=%0d cnt=%0d exp=0/2", err_a, cnt_a); end
        pulse_disarm();
        wait_done(0, 30, seen);
        d = first_diff(0);
        checks++; if (!seen || d != -1) begin errors++; $display("FAIL b2b_words seen=%b diff=%0d got_n=%0d exp_n=%0d", seen, d, got_a.size(), exp_q.size()); end
    endtask

    task automatic test_empty_mask();
        bit seen;
        do_reset();
        mask = 0; ready = 1; enable = 1;
        step();
        pulse_arm();
        checks++; if (err_b !== 2'd3 || active_b !== 1'b1) begin errors++; $display("FAIL empty_err err=%0d active=%b exp=3/1", err_b, active_b); end
        wait_done(1, 2, seen);
        checks++; if (!seen || active_b !== 1'b0) begin errors++; $display("FAIL empty_done seen=%b active=%b exp=1/0", seen, active_b); end
        repeat (3) step();
        checks++; if (got_b.size() != 0 || err_b !== 2'd3) begin errors++; $display("FAIL empty_words words=%0d err=%0d exp=0/3", got_b.size(), err_b); end
    endtask

    task automatic test_no_header();
        bit seen;
        int d;
        logic [31:0] m;
        do_reset();
        m = 32'($urandom_range(255, 1));
        mask = m; randomize_bus(); ready = 1; enable = 1;
        step();
        pulse_arm();
        capture = 1; model_sample(m, posbus, 0, 1, 8); step(); capture = 0;
        randomize_bus();
        repeat (12) step();
        pulse_disarm();
        wait_done(1, 30, seen);
        d = first_diff(1);
        checks++; if (!seen || d != -1 || cnt_b !== 32'd1) begin errors++; $display("FAIL nohdr_words seen=%b diff=%0d got_n=%0d exp_n=%0d cnt=%0d", seen, d, got_b.size(), exp_q.size(), cnt_b); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int d;
        do_reset();
        mask = 32'hF; randomize_bus(); ready = 0; enable = 1;
        step();
        pulse_arm();
        capture = 1; step(); capture = 0;
        step(); step();
        reset_n = 0;
        step();
        checks++; if (valid_a !== 1'b0 || dat_a !== 32'd0 || active_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL midrst_out valid=%b dat=%h active=%b done=%b exp=0", valid_a, dat_a, active_a, done_a); end
        checks++; if (err_a !== 2'd0 || cnt_a !== 32'd0) begin errors++; $display("FAIL midrst_status err=%0d cnt=%0d exp=0/0", err_a, cnt_a); end
        reset_n = 1;
        got_a.delete(); exp_q.delete();
        mask = 32'h5; randomize_bus(); ready = 1;
        step();
        pulse_arm();
        capture = 1; model_sample(32'h5, posbus, 1, 1, 32); step(); capture = 0;
        checks++; if (cnt_a !== 32'd1) begin errors++; $display("FAIL midrst_cnt got=%0d exp=1", cnt_a); end
        repeat (8) step();
        pulse_disarm();
        wait_done(0, 20, seen);
        d = first_diff(0);
        checks++; if (!seen || d != -1) begin errors++; $display("FAIL midrst_words seen=%b diff=%0d got_n=%0d exp_n=%0d", seen, d, got_a.size(), exp_q.size()); end
        step();
        arm = 1; disarm = 1; step(); arm = 0; disarm = 0;
        checks++; if (active_a !== 1'b0) begin errors++; $display("FAIL armdisarm_active got=%b exp=0", active_a); end
        capture = 1; step(); capture = 0;
        repeat (3) step();
        checks++; if (active_a !== 1'b0 || valid_a !== 1'b0 || cnt_a !== 32'd1) begin errors++; $display("FAIL armdisarm_idle active=%b valid=%b cnt=%0d exp=0/0/1", active_a, valid_a, cnt_a); end
    endtask

    task automatic test_random();
        bit seen;
        int d, ns, w;
        logic [31:0] m;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            m = 0;
            w = $urandom_range(6, 1);
            while ($countones(m) < w) m[$urandom_range(31, 0)] = 1'b1;
            mask = m; enable = 1; ready = 1;
            step();
            pulse_arm();
            ns = $urandom_range(6, 3);
            for (int s = 1; s <= ns; s++) begin
                randomize_bus();
                capture = 1; model_sample(m, posbus, 1, s, 32); step(); capture = 0;
                randomize_bus();
                for (int i = 0; i < 300; i++) begin
                    ready = ($urandom_range(3, 0) != 0);
                    step();
                    if (i > w + 4 && !valid_a) break;
                end
            end
            ready = 1;
            checks++; if (err_a !== 2'd0 || cnt_a !== 32'(ns)) begin errors++; $display("FAIL rand_status r=%0d err=%0d cnt=%0d exp=0/%0d", r, err_a, cnt_a, ns); end
            pulse_disarm();
            wait_done(0, 40, seen);
            d = first_diff(0);
            checks++; if (!seen || d != -1) begin errors++; $display("FAIL rand_words r=%0d seen=%b diff=%0d got_n=%0d exp_n=%0d", r, seen, d, got_a.size(), exp_q.size()); end
        end
    endtask

    initial begin
        reset_n = 0; arm = 0; disarm = 0; enable = 0; capture = 0; ready = 0; mask = 0; posbus = '0;
        test_reset();
        test_single();
        test_too_fast();
        test_overrun();
        test_back_to_back_stall();
        test_empty_mask();
        test_no_header();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcap_pos_packer.md
Name: pcap_pos_packer

Overview:
- Parametrised position-capture packer for the PCAP path; successor to the fixed 32-channel capture core.
- Accepts N position channels from the position bus and snapshots the channels selected by a mask on each gated capture strobe.
- Serialises each snapshot into 32-bit words, with an optional sample-count header, through an internal FIFO.
- Delivers words downstream on a valid/ready stream, with arm/disarm run control, active/done status and error reporting.

Parameters:
NUM_POS, 32, number of 32-bit position channels on posbus_i (1..64)
HDR_EN, 1, 1 = prepend the 32-bit sample-count header word to each sample
FIFO_AW, 8, FIFO address width; depth = 2**FIFO_AW words

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  synchronous reset, active-low
arm_i  in  1  single-cycle arm pulse
disarm_i  in  1  single-cycle disarm pulse
enable_i  in  1  capture gate (level)
capture_i  in  1  capture strobe (one sample per high cycle)
mask_i  in  NUM_POS  channel select; sampled on arm
posbus_i  in  NUM_POS*32  channel k at bits [32k+31:32k]
dat_o  out  32  output word
dat_valid_o  out  1  dat_o valid
dat_ready_i  in  1  downstream accept
active_o  out  1  high from arm until drain complete
done_o  out  1  one-cycle pulse at end of run
err_o  out  2  0 none, 1 capture too fast, 2 FIFO overrun, 3 empty mask
sample_cnt_o  out  32  samples accepted this run

Behaviour:
- Reset (reset_n_i=0 at a clock edge): state IDLE; FIFO flushed; all outputs 0; latched mask 0. Applies from any state, mid-sample included.
- W = popcount(mask) + HDR_EN words per sample, computed once at arm.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - arm_i: latch mask_i, clear err_o and sample_cnt_o, go to ACTIVE; active_o=1 from the next cycle.
  - If W=0: err_o=3 and go straight to DRAIN.
  - disarm_i is ignored.
- arm_i and disarm_i in the same cycle: disarm wins; no run starts from IDLE.
- ACTIVE, accepted capture: capture_i & enable_i with serialiser idle and FIFO free >= W.
  - All NUM_POS channels are snapshotted into a shadow register in the same cycle.
  - sample_cnt_o increments and wraps 2**32-1 -> 0.
  - Header value is the post-increment count, so the first sample carries 1.
- Serialiser:
  - Writes one word per cycle into the FIFO: header first, then masked channels in ascending index order.
  - Capture at edge n: first word written at edge n+1; dat_valid_o high after edge n+2 if the FIFO was empty.
  - Last word written at edge n+W; serialiser idle from edge n+W, so back-to-back captures are legal every W cycles.
- Errors in ACTIVE: first error latches, later errors are ignored, then go to DRAIN.
  - Capture while serialiser busy: err_o=1, capture dropped.
  - Capture with FIFO free < W: err_o=2, capture dropped.
  - A sample is never partially written.
- ACTIVE -> DRAIN on disarm_i or on a falling edge of enable_i.
- arm_i in ACTIVE or DRAIN is ignored.
- DRAIN:
  - Captures are ignored.
  - Any in-progress sample is completed.
  - When the serialiser is idle and the FIFO is empty: done_o pulses 1 cycle, active_o=0 that same cycle, go to IDLE.
- Stream:
  - FIFO is show-ahead; a word transfers on dat_valid_o & dat_ready_i.
  - While valid & !ready, dat_o and dat_valid_o hold stable.
  - A simultaneous FIFO write and read is legal at full and at empty.
  - FIFO full flag never overflows, guaranteed by the pre-check.
- sample_cnt_o and err_o hold after done until the next arm.

Decomposition:
- Shared package pcap_pkg: error code constants (ERR_NONE/TOO_FAST/OVERRUN/EMPTY_MASK), state encoding (IDLE/ACTIVE/DRAIN), POS_W=32 constant.
- One sub-module: pcap_sync_fifo (parametrised width/FIFO_AW, show-ahead, count output used for free-space check).
- Popcount and serialiser index walk stay in the top level.

Test Plan:
1. NUM_POS=32, HDR_EN=1, mask=0x0000_0005, posbus ch0=0x11, ch2=0x33; arm, enable, single capture, ready=1 -> words 1, 0x11, 0x33; first valid at n+2; disarm -> done_o one pulse, active_o=0, err_o=0.
2. Same mask, captures at n and n+2 (W=3) -> second dropped, err_o=1, sample_cnt_o=1, first sample (3 words) delivered intact, then done.
3. FIFO_AW=3, mask=0xF, HDR_EN=1 (W=5), dat_ready_i=0, captures every 5 cycles -> first accepted, second rejected (free 3<5), err_o=2; raise ready -> exactly 5 words out, then done.
4. Stall: ready toggles 1/0 every cycle during a 2-sample run -> dat_o stable while valid&!ready, all 2*W words in order, no loss or duplication.
5. HDR_EN=0, mask=0, arm -> err_o=3, done_o pulses within 2 cycles, no words emitted.
6. Reset mid-sample (reset_n_i=0 at word 2 of 5) -> all outputs 0 next cycle, FIFO empty; re-arm gives sample_cnt restart at 1; arm+disarm same cycle in IDLE -> stays IDLE.
